// File: rtl/multiword_add_seq_if.sv
// Handshake and data bundle for multiword_add_seq: operands and start in,
// busy/done status and the assembled result out.
interface multiword_add_seq_if #(
  parameter int WIDTH = 5,
  parameter int WORDS = 4
);
  logic                   start;
  logic [WIDTH*WORDS-1:0] a_in;
  logic [WIDTH*WORDS-1:0] b_in;
  logic                   c_in;
  logic                   busy;
  logic                   done;
  logic [WIDTH*WORDS-1:0] sum_out;
  logic                   c_out;
  logic                   ovf;

  modport master (
    output start, a_in, b_in, c_in,
    input  busy, done, sum_out, c_out, ovf
  );

  modport slave (
    input  start, a_in, b_in, c_in,
    output busy, done, sum_out, c_out, ovf
  );
endinterface

// File: rtl/multiword_add_seq.sv
// Extended-precision adder: streams WORDS slices of WIDTH bits through one
// n_ripple_adder, chaining the carry. Optional signed overflow: SIGNED_OVF_EN.

module n_ripple_adder #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);
  always_comb begin
    logic cy;
    cy = c_in;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    c_out = cy;
  end
endmodule

module multiword_add_seq #(
  parameter int WIDTH = 5,
  parameter int WORDS = 4
) (
  input logic                clk,
  input logic                rst_n,
  multiword_add_seq_if.slave s
);
  localparam int SEL_W = $clog2(WORDS);
  localparam int IDX_W = SEL_W + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state, state_nx;
  logic [IDX_W-1:0]            idx;
  logic                        carry;
  logic [WORDS-1:0][WIDTH-1:0] a_q, b_q, sum_q;
  logic                        c_out_q;
  logic [WIDTH-1:0]            add_sum;
  logic                        add_c;
  logic [SEL_W-1:0]            sel;
  logic                        accept;
  logic                        last_slice;

  assign sel        = idx[SEL_W-1:0];
  assign accept     = (state == IDLE || state == DONE) && s.start;
  assign last_slice = (state == RUN) && (idx == LAST);

  n_ripple_adder #(.N(WIDTH)) u_adder (
    .a     (a_q[sel]),
    .b     (b_q[sel]),
    .c_in  (carry),
    .sum   (add_sum),
    .c_out (add_c)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: state_nx gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (s.start) state_nx = RUN;
      RUN:     if (idx == LAST) state_nx = DONE;
      DONE:    state_nx = s.start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: operand and sum registers are reset too, so a reset leaves no stale data visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      carry   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else if (accept) begin
      a_q   <= s.a_in;
      b_q   <= s.b_in;
      carry <= s.c_in;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_q[sel] <= add_sum;
      carry      <= add_c;
      // idx parks on the top slice rather than wrapping past WORDS-1
      if (last_slice) c_out_q <= add_c;
      else            idx     <= idx + 1'b1;
    end
  end

  assign s.busy    = (state == RUN);
  assign s.done    = (state == DONE);
  assign s.sum_out = sum_q;
  assign s.c_out   = c_out_q;

`ifdef SIGNED_OVF_EN
  logic ovf_q;
  logic a_msb, b_msb;

  assign a_msb = a_q[WORDS-1][WIDTH-1];
  assign b_msb = b_q[WORDS-1][WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ovf_q <= 1'b0;
    else if (accept)     ovf_q <= 1'b0;
    else if (last_slice) ovf_q <= (a_msb == b_msb) && (add_sum[WIDTH-1] != a_msb);
  end

  assign s.ovf = ovf_q;
`else
  assign s.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: directed table, random ops against
// an arithmetic model, and hand-written back-to-back / mid-run reset sequences.
module tb_multiword_add_seq;
  localparam int W   = 5;
  localparam int N   = 4;
  localparam int TOT = W * N;
  localparam int MAX_WAIT = 40;
`ifdef SIGNED_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  multiword_add_seq_if #(.WIDTH(W), .WORDS(N)) bus ();
  multiword_add_seq #(.WIDTH(W), .WORDS(N)) dut (.clk(clk), .rst_n(rst_n), .s(bus.slave));

  typedef struct {
    logic [TOT-1:0] a;
    logic [TOT-1:0] b;
    logic           c;
    logic [TOT-1:0] sum;
    logic           cout;
    logic           ovf_en;  // overflow expected when the signed feature is built
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer addition and the two's-complement overflow rule.
  function automatic logic [TOT+1:0] model(input logic [TOT-1:0] a, b, input logic c);
    logic [TOT:0] full;
    logic         o;
    full = {1'b0, a} + {1'b0, b} + {{TOT{1'b0}}, c};
    o    = OVF_ON && (a[TOT-1] == b[TOT-1]) && (full[TOT-1] != a[TOT-1]);
    return {o, full};
  endfunction

  // Issue one op with start pulsed for a single cycle, scramble inputs after
  // acceptance, and report result plus edges from accept to done.
  task automatic run_op(input logic [TOT-1:0] a, b, input logic c,
                        output logic [TOT-1:0] sum, output logic cout, output logic ovf,
                        output int lat);
    @(negedge clk);
    bus.a_in = a; bus.b_in = b; bus.c_in = c; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_in = TOT'($urandom); bus.b_in = TOT'($urandom); bus.c_in = 1'($urandom);
    lat = 1;
    while (!bus.done && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
    sum = bus.sum_out; cout = bus.c_out; ovf = bus.ovf;
    if (!bus.done) check("done_timeout", 32'(lat), 32'(N + 1));
    @(negedge clk);
    check("done_one_cycle", {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_sum"},  32'(bus.sum_out), 32'd0);
    check({tag, "_cout"}, 32'(bus.c_out), 32'd0);
    check({tag, "_ovf"},  32'(bus.ovf), 32'd0);
  endtask

  initial begin
    vec_t           tbl[8];
    logic [TOT-1:0] sum, a, b;
    logic [TOT+1:0] ref_v;
    logic           cout, ovf, c;
    int             lat, dones;

    tbl[0] = '{20'h00001, 20'h00001, 1'b0, 20'h00002, 1'b0, 1'b0};
    tbl[1] = '{20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 1'b1, 1'b0};
    tbl[2] = '{20'h00000, 20'h00000, 1'b1, 20'h00001, 1'b0, 1'b0};
    tbl[3] = '{20'h12345, 20'h0ABCD, 1'b0, 20'h1CF12, 1'b0, 1'b0};
    tbl[4] = '{20'h7FFFF, 20'h00001, 1'b0, 20'h80000, 1'b0, 1'b1};
    tbl[5] = '{20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1, 1'b1};
    tbl[6] = '{20'hFFFFF, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b1, 1'b0};
    tbl[7] = '{20'h0001F, 20'h00001, 1'b0, 20'h00020, 1'b0, 1'b0};

    bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.c_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state("reset");
    #20 rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].c, sum, cout, ovf, lat);
      check($sformatf("tbl%0d_sum", i), 32'(sum), 32'(tbl[i].sum));
      check($sformatf("tbl%0d_cout", i), 32'(cout), 32'(tbl[i].cout));
      check($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(OVF_ON & tbl[i].ovf_en));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(N + 1));
    end

    for (int i = 0; i < 40; i++) begin
      a = TOT'($urandom); b = TOT'($urandom); c = 1'($urandom);
      if (i % 8 == 0) b = ~a;  // force long carry chains
      ref_v = model(a, b, c);
      run_op(a, b, c, sum, cout, ovf, lat);
      check($sformatf("rnd%0d", i), {9'd0, lat[0], ovf, cout, sum}, {9'd0, 1'(N + 1), ref_v[TOT+1:0]});
    end

    // start held high through DONE: second op must follow with no IDLE cycle
    @(negedge clk);
    bus.a_in = 20'h0F0F0; bus.b_in = 20'h01111; bus.c_in = 1'b0; bus.start = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.done && lat < MAX_WAIT);
    check("b2b_first_sum", 32'(bus.sum_out), 32'(model(20'h0F0F0, 20'h01111, 1'b0)));
    bus.a_in = 20'hABCDE; bus.b_in = 20'h54321; bus.c_in = 1'b1;
    @(negedge clk);
    check("b2b_no_idle", {30'd0, bus.busy, bus.done}, 32'b10);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < MAX_WAIT) begin @(negedge clk); lat++; end
    ref_v = model(20'hABCDE, 20'h54321, 1'b1);
    check("b2b_second", {bus.c_out, bus.sum_out}, 32'(ref_v[TOT:0]));
    check("b2b_second_latency", 32'(lat), 32'(N));

    // start pulsed during RUN is ignored: exactly one done, first op's result
    @(negedge clk);
    bus.a_in = 20'h00321; bus.b_in = 20'h00123; bus.c_in = 1'b0; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    bus.a_in = 20'hFFFFF; bus.b_in = 20'hFFFFF; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done) begin
        dones++;
        check("ignore_sum", {bus.c_out, bus.sum_out}, 32'h00444);
      end
      @(negedge clk);
    end
    check("ignore_done_count", 32'(dones), 32'd1);

    // reset after two slices captured: immediate clear, no done afterwards
    @(negedge clk);
    bus.a_in = 20'hFFFFF; bus.b_in = 20'hFFFFF; bus.c_in = 1'b1; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrun_reset");
    #10 rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("midrun_no_done", 32'(dones), 32'd0);
    run_op(20'h12345, 20'h0ABCD, 1'b0, sum, cout, ovf, lat);
    check("after_reset_sum", 32'(sum), 32'h1CF12);
    check("after_reset_cout", 32'(cout), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
